i2c_write_sequencer: RTL and testbench

I2C_WRITE_SEQUENCER -- requirements
Module: i2c_write_sequencer

---
 rtl/i2c_write_sequencer_pkg.sv | 35 +++
 rtl/i2c_phase_timer.sv | 33 +++
 rtl/i2c_write_sequencer.sv | 172 +++++++++++++++++
 tb/tb_i2c_write_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_write_sequencer_pkg.sv
// Shared definitions for the I2C write sequencer: one-hot state map,
// default phase lengths and the address-byte helper.
package i2c_write_sequencer_pkg;

  localparam int ACK_CYCLES_DEF = 4;
  localparam int TIMEOUT_DEF    = 255;
  localparam int TMR_W          = 8;

  localparam int S_IDLE      = 0;
  localparam int S_LOAD_ADDR = 1;
  localparam int S_SEND      = 2;
  localparam int S_ACK       = 3;
  localparam int S_FETCH     = 4;
  localparam int S_LOAD_DATA = 5;
  localparam int S_STOP      = 6;
  localparam int S_FINISH    = 7;
  localparam int NUM_STATES  = 8;

  typedef enum logic [NUM_STATES-1:0] {
    ST_IDLE      = 8'(1 << S_IDLE),
    ST_LOAD_ADDR = 8'(1 << S_LOAD_ADDR),
    ST_SEND      = 8'(1 << S_SEND),
    ST_ACK       = 8'(1 << S_ACK),
    ST_FETCH     = 8'(1 << S_FETCH),
    ST_LOAD_DATA = 8'(1 << S_LOAD_DATA),
    ST_STOP      = 8'(1 << S_STOP),
    ST_FINISH    = 8'(1 << S_FINISH)
  } state_t;

  // Address byte on the wire: 7-bit address followed by the write bit (0).
  function automatic logic [7:0] addr_write_byte(input logic [6:0] addr);
    return {addr, 1'b0};
  endfunction

endpackage

// File: rtl/i2c_phase_timer.sv
// Shared up-counter for the SEND timeout and the ACK phase length.
// Cleared by load, counts while enabled, flags the last cycle of the phase.
module i2c_phase_timer
  import i2c_write_sequencer_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_last;

  assign w_last = i_limit - 1'b1;
  assign o_tc   = i_en && (r_cnt == w_last);

  // Holds at the terminal value so a stalled enable can never wrap.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_write_sequencer.sv
// Sequences one I2C write transaction: address byte, CMD_LEN data bytes,
// per-byte ACK check, timeout on the byte writer, then STOP and DONE.
module i2c_write_sequencer
  import i2c_write_sequencer_pkg::*;
#(
  parameter int ACK_CYCLES = ACK_CYCLES_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [6:0] i_cmd_addr,
  input  logic [3:0] i_cmd_len,
  input  logic [7:0] i_wr_data,
  output logic       o_wr_data_req,
  output logic       o_byte_start,
  output logic [7:0] o_byte_din,
  input  logic       i_byte_done,
  input  logic       i_ack_in,
  output logic       o_stop_pulse,
  output logic       o_done,
  output logic       o_nack_err,
  output logic       o_timeout_err,
  output logic [3:0] o_bytes_sent
);

  state_t           r_state;
  logic             r_cmd_ready;
  logic             r_wr_data_req;
  logic             r_byte_start;
  logic [7:0]       r_byte_din;
  logic             r_stop_pulse;
  logic             r_done;
  logic             r_nack_err;
  logic             r_timeout_err;
  logic [3:0]       r_bytes_sent;
  logic [3:0]       r_remaining;
  logic             r_is_data;

  logic             w_tmr_load;
  logic             w_tmr_en;
  logic             w_tmr_tc;
  logic [TMR_W-1:0] w_tmr_limit;

  // One counter serves both phases; the limit follows the current state.
  assign w_tmr_load  = r_byte_start || ((r_state == ST_SEND) && i_byte_done);
  assign w_tmr_en    = (r_state == ST_SEND) || (r_state == ST_ACK);
  assign w_tmr_limit = (r_state == ST_ACK) ? TMR_W'(ACK_CYCLES) : TMR_W'(TIMEOUT);

  i2c_phase_timer #(
    .W (TMR_W)
  ) u_phase_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_tmr_load),
    .i_en    (w_tmr_en),
    .i_limit (w_tmr_limit),
    .o_tc    (w_tmr_tc)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_cmd_ready   <= 1'b1;
      r_wr_data_req <= 1'b0;
      r_byte_start  <= 1'b0;
      r_byte_din    <= '0;
      r_stop_pulse  <= 1'b0;
      r_done        <= 1'b0;
      r_nack_err    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_bytes_sent  <= '0;
      r_remaining   <= '0;
      r_is_data     <= 1'b0;
    end else begin
      r_cmd_ready   <= 1'b0;
      r_wr_data_req <= 1'b0;
      r_byte_start  <= 1'b0;
      r_stop_pulse  <= 1'b0;
      r_done        <= 1'b0;
      r_nack_err    <= 1'b0;
      r_timeout_err <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            r_remaining  <= i_cmd_len;
            r_bytes_sent <= '0;
            r_is_data    <= 1'b0;
            r_byte_din   <= addr_write_byte(i_cmd_addr);
            r_byte_start <= 1'b1;
            r_state      <= ST_LOAD_ADDR;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end

        ST_LOAD_ADDR: r_state <= ST_SEND;

        // BYTE_DONE is checked first so it wins over a coincident timeout.
        ST_SEND: begin
          if (i_byte_done) begin
            r_state <= ST_ACK;
          end else if (w_tmr_tc) begin
            r_stop_pulse  <= 1'b1;
            r_timeout_err <= 1'b1;
            r_state       <= ST_STOP;
          end
        end

        ST_ACK: begin
          if (w_tmr_tc) begin
            if (i_ack_in) begin
              r_stop_pulse <= 1'b1;
              r_nack_err   <= 1'b1;
              r_state      <= ST_STOP;
            end else begin
              if (r_is_data) begin
                r_bytes_sent <= r_bytes_sent + 4'd1;
              end
              if (r_remaining != 4'd0) begin
                r_remaining   <= r_remaining - 4'd1;
                r_wr_data_req <= 1'b1;
                r_state       <= ST_FETCH;
              end else begin
                r_stop_pulse <= 1'b1;
                r_state      <= ST_STOP;
              end
            end
          end
        end

        // The host buffer is show-ahead: WR_DATA is valid alongside the pop.
        ST_FETCH: begin
          r_byte_din   <= i_wr_data;
          r_byte_start <= 1'b1;
          r_is_data    <= 1'b1;
          r_state      <= ST_LOAD_DATA;
        end

        ST_LOAD_DATA: r_state <= ST_SEND;

        ST_STOP: begin
          r_done  <= 1'b1;
          r_state <= ST_FINISH;
        end

        ST_FINISH: begin
          r_cmd_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end

        default: begin
          r_cmd_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready   = r_cmd_ready;
  assign o_wr_data_req = r_wr_data_req;
  assign o_byte_start  = r_byte_start;
  assign o_byte_din    = r_byte_din;
  assign o_stop_pulse  = r_stop_pulse;
  assign o_done        = r_done;
  assign o_nack_err    = r_nack_err;
  assign o_timeout_err = r_timeout_err;
  assign o_bytes_sent  = r_bytes_sent;

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Table-driven bench for i2c_write_sequencer with a byte-writer/slave responder
// and a scoreboard of expected BYTE_DIN values.
module tb_i2c_write_sequencer;

  localparam int ACK = 4;
  localparam int TMO = 255;
  localparam int NV  = 10;
  localparam logic [127:0] DATA = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [3:0] cmd_len = '0;
  logic [7:0] wr_data = '0;
  logic       byte_done = 1'b0;
  logic       ack_in = 1'b0;
  logic       o_cmd_ready, o_wr_data_req, o_byte_start, o_stop_pulse, o_done;
  logic       o_nack_err, o_timeout_err;
  logic [7:0] o_byte_din;
  logic [3:0] o_bytes_sent;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [6:0]   addr;
    logic [3:0]   len;
    logic [127:0] data;
    int           nack_at;
    int           slow_at;
    int           slow_dly;
    bit           noise;
    int           rst_ack;
    logic [3:0]   exp_sent;
    bit           exp_nack;
    bit           exp_tout;
  } vec_t;

  vec_t vecs[NV];

  i2c_write_sequencer #(
    .ACK_CYCLES (ACK),
    .TIMEOUT    (TMO)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_addr    (cmd_addr),
    .i_cmd_len     (cmd_len),
    .i_wr_data     (wr_data),
    .o_wr_data_req (o_wr_data_req),
    .o_byte_start  (o_byte_start),
    .o_byte_din    (o_byte_din),
    .i_byte_done   (byte_done),
    .i_ack_in      (ack_in),
    .o_stop_pulse  (o_stop_pulse),
    .o_done        (o_done),
    .o_nack_err    (o_nack_err),
    .o_timeout_err (o_timeout_err),
    .o_bytes_sent  (o_bytes_sent)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc, bd_wait, ack_cnt, byte_idx, fifo_idx, req_cnt, stop_cnt;
    int stop_cyc, last_ack_cyc, last_bs_cyc, exp_req_cyc, exp_bs_cyc, exp_n, bad;
    bit ack_act, want_nack, pop_pending, done_seen, aborted;
    logic [7:0] exp_b;

    exp_q.delete();
    for (int i = 0; i <= int'(v.len); i++) begin
      exp_q.push_back((i == 0) ? {v.addr, 1'b0} : v.data[8*(i-1) +: 8]);
      if ((i == v.slow_at && v.slow_dly > TMO) || i == v.nack_at || i == v.rst_ack) break;
    end
    exp_n = exp_q.size();

    if (v.noise) begin
      byte_done = 1'b1;
      @(negedge clk);
      byte_done = 1'b0;
      chk("idle_bdone_ready", o_cmd_ready, 1);
      chk("idle_bdone_nostart", o_byte_start, 0);
    end

    chk("ready_before_cmd", o_cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_addr  = v.addr;
    cmd_len   = v.len;
    wr_data   = v.data[7:0];
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    chk("addr_bs_latency", o_byte_start, 1);
    chk("busy_not_ready", o_cmd_ready, 0);

    bd_wait = 0; ack_cnt = 0; byte_idx = -1; fifo_idx = 0; req_cnt = 0; stop_cnt = 0;
    stop_cyc = -10; last_ack_cyc = -10; last_bs_cyc = 0; exp_req_cyc = -1; exp_bs_cyc = -1;
    ack_act = 0; want_nack = 0; pop_pending = 0; done_seen = 0; aborted = 0;

    for (cyc = 0; cyc < 4000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      // host buffer: pop takes effect after the edge that consumed the head
      if (pop_pending) begin
        fifo_idx++;
        pop_pending = 0;
      end
      wr_data = v.data[8*fifo_idx +: 8];
      if (o_wr_data_req) begin
        req_cnt++;
        pop_pending = 1;
        chk("wr_req_timing", cyc, exp_req_cyc);
      end
      // slave: drives the opposite level until the last ACK cycle
      if (ack_act) begin
        ack_cnt++;
        if (v.rst_ack == byte_idx && ack_cnt == 3) begin
          rst_n   = 1'b0;
          aborted = 1;
        end
        ack_in = (ack_cnt == ACK) ? want_nack : ~want_nack;
        if (ack_cnt == ACK) begin
          ack_act      = 0;
          last_ack_cyc = cyc;
          if (!want_nack && byte_idx < int'(v.len)) begin
            exp_req_cyc = cyc + 1;
            exp_bs_cyc  = cyc + 2;
          end
        end
      end
      if (bd_wait > 0) begin
        bd_wait--;
        byte_done = (bd_wait == 0);
        if (bd_wait == 0) begin
          ack_act = 1;
          ack_cnt = 0;
        end
      end else begin
        byte_done = 1'b0;
      end
      cmd_valid = v.noise && !o_cmd_ready && (cyc % 2 == 1);
      cmd_addr  = 7'(cyc);
      cmd_len   = 4'hF;

      if (o_byte_start) begin
        byte_idx++;
        chk("sb_has_entry", (exp_q.size() > 0) ? 32'd1 : 32'd0, 1);
        if (exp_q.size() > 0) begin
          exp_b = exp_q.pop_front();
          chk("byte_din", o_byte_din, exp_b);
        end
        if (byte_idx > 0) chk("data_bs_timing", cyc, exp_bs_cyc);
        last_bs_cyc = cyc;
        bd_wait     = (byte_idx == v.slow_at) ? v.slow_dly : 1 + (byte_idx % 3);
        want_nack   = (byte_idx == v.nack_at);
      end
      if (o_stop_pulse) begin
        stop_cnt++;
        stop_cyc = cyc;
        chk("nack_err", o_nack_err, v.exp_nack);
        chk("timeout_err", o_timeout_err, v.exp_tout);
        if (v.exp_tout) chk("timeout_cycle", cyc - last_bs_cyc, TMO + 1);
        else            chk("stop_timing", cyc, last_ack_cyc + 1);
      end else if (o_nack_err || o_timeout_err) begin
        chk("err_with_stop", o_stop_pulse, 1);
      end
      if (o_done) begin
        done_seen = 1;
        chk("done_after_stop", cyc, stop_cyc + 1);
        chk("bytes_sent", o_bytes_sent, v.exp_sent);
      end
      if (done_seen || aborted) break;
    end
    cmd_valid = 1'b0;
    byte_done = 1'b0;
    chk("txn_completes", (done_seen || aborted) ? 32'd1 : 32'd0, 1);

    if (aborted) begin
      @(negedge clk);
      chk("rst_ready", o_cmd_ready, 1);
      chk("rst_byte_start", o_byte_start, 0);
      chk("rst_stop", o_stop_pulse, 0);
      chk("rst_done", o_done, 0);
      chk("rst_byte_din", o_byte_din, 0);
      chk("rst_bytes_sent", o_bytes_sent, 0);
      rst_n = 1'b1;
      bad = 0;
      repeat (6) begin
        @(negedge clk);
        if (o_done || o_stop_pulse || o_byte_start) bad++;
      end
      chk("quiet_after_abort", bad, 0);
      exp_q.delete();
    end else begin
      @(negedge clk);
      chk("ready_after_done", o_cmd_ready, 1);
      chk("stop_count", stop_cnt, 1);
      chk("wr_req_count", req_cnt, exp_n - 1);
      chk("sb_drained", exp_q.size(), 0);
    end
  endtask

  initial begin
    vecs[0] = '{7'h50, 4'd2,  128'h3CA5, -1, -1, 0,   1'b0, -1, 4'd2,  1'b0, 1'b0};
    vecs[1] = '{7'h27, 4'd0,  128'h0,    -1, -1, 0,   1'b0, -1, 4'd0,  1'b0, 1'b0};
    vecs[2] = '{7'h11, 4'd3,  DATA,       2, -1, 0,   1'b0, -1, 4'd1,  1'b1, 1'b0};
    vecs[3] = '{7'h3A, 4'd1,  DATA,      -1,  0, 300, 1'b0, -1, 4'd0,  1'b0, 1'b1};
    vecs[4] = '{7'h7F, 4'd2,  DATA,      -1,  1, 255, 1'b0, -1, 4'd2,  1'b0, 1'b0};
    vecs[5] = '{7'h00, 4'd2,  DATA,      -1,  2, 256, 1'b0, -1, 4'd1,  1'b0, 1'b1};
    vecs[6] = '{7'h55, 4'd15, DATA,      -1, -1, 0,   1'b1, -1, 4'd15, 1'b0, 1'b0};
    vecs[7] = '{7'h33, 4'd1,  DATA,       0, -1, 0,   1'b0, -1, 4'd0,  1'b1, 1'b0};
    vecs[8] = '{7'h42, 4'd2,  DATA,      -1, -1, 0,   1'b0,  1, 4'd0,  1'b0, 1'b0};
    vecs[9] = '{7'h50, 4'd2,  128'h3CA5, -1, -1, 0,   1'b0, -1, 4'd2,  1'b0, 1'b0};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", o_cmd_ready, 1);
    chk("reset_byte_start", o_byte_start, 0);
    chk("reset_wr_req", o_wr_data_req, 0);
    chk("reset_stop", o_stop_pulse, 0);
    chk("reset_done", o_done, 0);
    chk("reset_errs", {o_nack_err, o_timeout_err}, 0);
    chk("reset_byte_din", o_byte_din, 0);
    chk("reset_bytes_sent", o_bytes_sent, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i]);
      repeat (2) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
